// File: rtl/wb_trace_fifo.sv
// Write-back trace capture FIFO: records register-file writes retiring in WB with a
// sequence tag. The FIFO is first-word-fall-through and counts events dropped on overflow.
module wb_trace_fifo #(
    parameter int   DEPTH     = 8,
    parameter logic FILTER_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              debug_wb_pc,
    input  logic [3:0]               debug_wb_rf_wen,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [31:0]              debug_wb_rf_wdata,
    input  logic                     trace_en,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [84:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [84:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          valid_r;
    logic [15:0]   seq_r;
    logic          overflow_r;
    logic [15:0]   overflow_cnt_r;

    logic          capture_s;
    logic          pop_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic [84:0]   entry_s;

    // Capture qualification, handshake decode and next occupancy
    always_comb begin
        capture_s   = 1'b0;
        pop_s       = 1'b0;
        full_s      = 1'b0;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        count_nxt_s = count_r;
        entry_s     = {seq_r, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};

        capture_s = trace_en & (debug_wb_rf_wen != 4'h0)
                  & ~(FILTER_R0 & (debug_wb_rf_wnum == 5'd0));
        pop_s     = valid_r & out_ready;
        full_s    = (count_r == CW'(DEPTH));
        // A full FIFO still accepts an event when the head leaves in the same cycle
        push_s    = capture_s & (~full_s | pop_s);
        drop_s    = capture_s & full_s & ~pop_s;

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy, sequence tag and overflow tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r       <= AW'(0);
            rd_ptr_r       <= AW'(0);
            count_r        <= CW'(0);
            valid_r        <= 1'b0;
            seq_r          <= 16'h0000;
            overflow_r     <= 1'b0;
            overflow_cnt_r <= 16'h0000;
        end else if (flush) begin
            wr_ptr_r       <= AW'(0);
            rd_ptr_r       <= AW'(0);
            count_r        <= CW'(0);
            valid_r        <= 1'b0;
            overflow_r     <= 1'b0;
            overflow_cnt_r <= 16'h0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (capture_s) begin
                seq_r <= seq_r + 16'h0001;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (overflow_cnt_r != 16'hFFFF) begin
                    overflow_cnt_r <= overflow_cnt_r + 16'h0001;
                end
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != CW'(0));
        end
    end

    // Entry storage; contents are never cleared, only overwritten
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign out_valid    = valid_r;
    assign out_data     = mem_r[rd_ptr_r];
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign overflow_cnt = overflow_cnt_r;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized + directed bench for wb_trace_fifo: a queue-based reference model feeds a
// scoreboard that a negedge monitor drains on every output handshake.
module tb_wb_trace_fifo;

    localparam int   DEPTH     = 8;
    localparam logic FILTER_R0 = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [84:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] overflow_cnt;

    wb_trace_fifo #(.DEPTH(DEPTH), .FILTER_R0(FILTER_R0)) dut (
        .clk(clk), .rst(rst),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .trace_en(trace_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [84:0] exp_q[$];
    int          m_cnt  = 0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_ocnt = 16'h0;
    logic [15:0] m_seq  = 16'h0;

    task automatic chk(input string name, input logic [84:0] act, input logic [84:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: each accepted head entry must match the oldest expected one
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pop_with_empty_model", 85'(out_valid), 85'(0));
            end else begin
                chk("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Advance one clock, apply the transfer rules to the model, compare status outputs
    task automatic tick();
        logic cap;
        logic pop;
        @(posedge clk);
        #1;
        cap = trace_en && (debug_wb_rf_wen != 4'h0) && !(FILTER_R0 && debug_wb_rf_wnum == 5'd0);
        pop = (m_cnt > 0) && out_ready;
        if (rst) begin
            m_cnt = 0; m_ovf = 1'b0; m_ocnt = 16'h0; m_seq = 16'h0;
            exp_q.delete();
        end else if (flush) begin
            m_cnt = 0; m_ovf = 1'b0; m_ocnt = 16'h0;
            exp_q.delete();
        end else begin
            if (pop) m_cnt = m_cnt - 1;
            if (cap) begin
                if (m_cnt < DEPTH) begin
                    exp_q.push_back({m_seq, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata});
                    m_cnt = m_cnt + 1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_ocnt != 16'hFFFF) m_ocnt = m_ocnt + 16'h1;
                end
                m_seq = m_seq + 16'h1;
            end
        end
        chk("count", 85'(count), 85'(m_cnt));
        chk("out_valid", 85'(out_valid), 85'(m_cnt != 0));
        chk("overflow", 85'(overflow), 85'(m_ovf));
        chk("overflow_cnt", 85'(overflow_cnt), 85'(m_ocnt));
    endtask

    task automatic set_ev(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        trace_en = 1'b1; debug_wb_rf_wen = 4'hF;
        debug_wb_pc = pc; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
    endtask

    task automatic idle();
        trace_en = 1'b0; debug_wb_rf_wen = 4'h0;
    endtask

    task automatic events(input int n);
        for (int i = 0; i < n; i++) begin
            set_ev(32'h8000_0000 + 32'(i * 4), 5'(i % 31 + 1), $urandom);
            tick();
        end
        idle();
    endtask

    task automatic drain();
        idle(); out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; trace_en = 1'b0;
        debug_wb_pc = 32'h0; debug_wb_rf_wen = 4'h0; debug_wb_rf_wnum = 5'd0;
        debug_wb_rf_wdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single write with fixed values
        set_ev(32'hBFC0_0000, 5'd5, 32'h1234_5678);
        tick();
        idle();
        chk("single_data", out_data, {16'h0000, 32'hBFC0_0000, 5'd5, 32'h1234_5678});
        chk("single_count", 85'(count), 85'(1));

        // Writes to r0 are filtered and do not advance seq
        set_ev(32'hBFC0_0004, 5'd0, 32'hDEAD_BEEF);
        tick();
        idle();
        chk("r0_count", 85'(count), 85'(1));
        drain();
        set_ev(32'hBFC0_0008, 5'd7, 32'h0000_0077);
        tick();
        idle();
        chk("r0_seq", 85'(out_data[84:69]), 85'(1));
        drain();

        // Overflow: fresh reset, ten events into an eight-deep FIFO
        rst = 1'b1; tick(); rst = 1'b0;
        events(10);
        chk("ovf_count", 85'(count), 85'(8));
        chk("ovf_flag", 85'(overflow), 85'(1));
        chk("ovf_cnt", 85'(overflow_cnt), 85'(2));
        chk("ovf_head_seq", 85'(out_data[84:69]), 85'(0));
        drain();
        events(1);
        chk("ovf_next_seq", 85'(out_data[84:69]), 85'(10));
        drain();

        // Flush wins against a same-cycle capture
        events(3);
        set_ev(32'hA000_0000, 5'd3, 32'h3333_3333);
        flush = 1'b1;
        tick();
        flush = 1'b0; idle();
        chk("flush_count", 85'(count), 85'(0));
        chk("flush_valid", 85'(out_valid), 85'(0));
        chk("flush_ovf", 85'(overflow), 85'(0));
        events(1);
        chk("flush_seq", 85'(out_data[84:69]), 85'(14));
        drain();

        // Full FIFO with simultaneous push and pop
        events(8);
        set_ev(32'hC000_0000, 5'd9, 32'h9999_9999);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; idle();
        chk("full_pp_count", 85'(count), 85'(8));
        chk("full_pp_ovfcnt", 85'(overflow_cnt), 85'(0));
        drain();

        // Mid-stream reset with overflow pending
        events(9);
        out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0;
        chk("mid_count_pre", 85'(count), 85'(5));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_count", 85'(count), 85'(0));
        chk("mid_ovfcnt", 85'(overflow_cnt), 85'(0));
        events(1);
        chk("mid_seq", 85'(out_data[84:69]), 85'(0));
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            trace_en          = ($urandom_range(0, 9) < 8);
            debug_wb_rf_wen   = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            debug_wb_rf_wnum  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            debug_wb_pc       = $urandom;
            debug_wb_rf_wdata = $urandom;
            out_ready         = ($urandom_range(0, 2) != 0);
            flush             = ($urandom_range(0, 79) == 0);
            rst               = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        drain();
        chk("final_empty", 85'(exp_q.size()), 85'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, range 2..64.
REQ-002 Parameter FILTER_R0, default 1: when 1, writes to register 0 are not captured.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port debug_wb_pc  input  32: PC of the instruction retiring in WB.
REQ-006 Port debug_wb_rf_wen  input  4: register-file write byte enables from WB.
REQ-007 Port debug_wb_rf_wnum  input  5: destination register number.
REQ-008 Port debug_wb_rf_wdata  input  32: write data.
REQ-009 Port trace_en  input  1: capture enable.
REQ-010 Port flush  input  1: clears FIFO contents and overflow state.
REQ-011 Port out_valid  output  1: head entry available.
REQ-012 Port out_ready  input  1: consumer accepts the head entry.
REQ-013 Port out_data  output  85: {seq[15:0], pc[31:0], wnum[4:0], wdata[31:0]}, MSB first.
REQ-014 Port count  output  $clog2(DEPTH)+1: current occupancy.
REQ-015 Port overflow  output  1: sticky flag; at least one event dropped.
REQ-016 Port overflow_cnt  output  16: number of dropped events.

Function
REQ-017 The capture event SHALL be trace_en & (debug_wb_rf_wen != 0) & ~(FILTER_R0 & debug_wb_rf_wnum == 0), evaluated combinationally each cycle.
REQ-018 A 16-bit seq counter SHALL increment by 1, wrapping 16'hFFFF->0, on every capture event (accepted or dropped); each stored entry SHALL carry the seq value from before the increment.
REQ-019 Pop SHALL occur when out_valid & out_ready.
REQ-020 Push SHALL occur on a capture event when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-021 When a capture event occurs with count == DEPTH and no pop, the event SHALL be dropped; overflow SHALL be set; overflow_cnt SHALL increment, saturating at 16'hFFFF.
REQ-022 The FIFO SHALL be first-word-fall-through: out_valid = (count != 0); out_data = head entry, held stable until popped.
REQ-023 Latency: an event pushed into an empty FIFO in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push alone +1; pop alone -1.
REQ-025 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-026 Entries SHALL be delivered in capture order, with no duplication or loss except drops under REQ-021.
REQ-027 Flush SHALL, on the next edge, set count=0, reset both pointers, clear overflow and overflow_cnt; seq SHALL be unchanged.
REQ-028 Flush with a simultaneous capture event: flush wins; the event SHALL NOT be stored or counted as dropped, and seq SHALL NOT increment.
REQ-029 Flush with out_valid & out_ready: the head entry SHALL be considered consumed; no further effect.
REQ-030 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-031 On rst=1 at a clock edge: count=0, pointers=0, seq=0, overflow=0, overflow_cnt=0, out_valid=0; rst SHALL take priority over flush, push and pop.
REQ-032 Storage contents need not be cleared; out_data is don't-care while out_valid=0.
REQ-033 Reset asserted mid-stream SHALL discard all stored entries; no entry SHALL be delivered after reset unless it is captured after reset deasserts.

Verification
REQ-034 Single write: wen=4'hF, wnum=5, wdata=32'h1234_5678, pc=32'hBFC0_0000, out_ready=0 -> next cycle out_valid=1, out_data={16'h0000, 32'hBFC0_0000, 5'd5, 32'h1234_5678}, count=1.
REQ-035 R0 filter: wnum=0, wen=4'hF with FILTER_R0=1 -> no push, count stays 0, seq stays 0; with FILTER_R0=0 -> entry pushed.
REQ-036 Overflow: DEPTH=8, out_ready=0, 10 consecutive events -> count=8, overflow=1, overflow_cnt=2, head seq=0; drain -> seq 0..7 in order, then seq 10 for the next capture.
REQ-037 Full plus simultaneous push/pop: count=8, out_ready=1 and event in the same cycle -> event accepted, count stays 8, overflow_cnt unchanged.
REQ-038 Flush versus capture: 3 entries stored, flush=1 with a capture event in the same cycle -> next cycle count=0, out_valid=0, overflow=0, seq unchanged.
REQ-039 Mid-stream reset: 5 entries stored, overflow=1, rst pulsed 1 cycle -> count=0, overflow_cnt=0, seq=0; the first post-reset capture carries seq=0.
